// File: rtl/ascon_pkg.sv
// Shared ASCON constants: core modes, data types, arbiter FSM states and defaults.
package ascon_pkg;

  localparam int unsigned NREQ_DEFAULT = 2;

  localparam logic [3:0] M_NOP  = 4'd0;
  localparam logic [3:0] M_ENC  = 4'd1;
  localparam logic [3:0] M_DEC  = 4'd2;
  localparam logic [3:0] M_HASH = 4'd3;
  localparam logic [3:0] M_XOF  = 4'd4;

  localparam logic [3:0] D_NULL  = 4'd0;
  localparam logic [3:0] D_NONCE = 4'd1;
  localparam logic [3:0] D_AD    = 4'd2;
  localparam logic [3:0] D_MSG   = 4'd3;
  localparam logic [3:0] D_TAG   = 4'd4;
  localparam logic [3:0] D_HASH  = 4'd5;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StRel} arb_state_e;

endpackage

// File: rtl/ascon_arb_pick.sv
// Requester selection for ascon_arbiter. ASCON_ARB_RR_EN selects round-robin after the
// last owner; otherwise fixed priority with the lowest eligible index winning.
module ascon_arb_pick
  import ascon_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0]         elig_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         pick_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);

  localparam int unsigned IW = $clog2(NREQ);

`ifdef ASCON_ARB_RR_EN
  int unsigned cand;

  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    // Scan starting just after the last owner so it is considered last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_i) + k) % NREQ;
      if (!valid_o && elig_i[cand]) begin
        pick_o[cand] = 1'b1;
        idx_o        = IW'(cand);
        valid_o      = 1'b1;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        pick_o    = '0;
        pick_o[i] = 1'b1;
        idx_o     = IW'(i);
        valid_o   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ascon_arbiter.sv
// Shares one ascon_core among NREQ requesters; one operation in flight at a time.
// Arbitration policy chosen by ASCON_ARB_RR_EN (see ascon_arb_pick).
module ascon_arbiter
  import ascon_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEFAULT,
  parameter  int unsigned CCW   = 32,
  localparam int unsigned CCWD8 = CCW / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  r_req,
  output logic [NREQ-1:0]                  r_gnt,
  output logic [NREQ-1:0]                  r_done,
  input  logic [NREQ-1:0][3:0]             r_mode,
  input  logic [NREQ-1:0][CCW-1:0]         r_key,
  input  logic [NREQ-1:0]                  r_key_valid,
  output logic [NREQ-1:0]                  r_key_ready,
  input  logic [NREQ-1:0][CCW-1:0]         r_bdi,
  input  logic [NREQ-1:0][CCWD8-1:0]       r_bdi_valid,
  input  logic [NREQ-1:0][3:0]             r_bdi_type,
  input  logic [NREQ-1:0]                  r_bdi_eot,
  input  logic [NREQ-1:0]                  r_bdi_eoi,
  output logic [NREQ-1:0]                  r_bdi_ready,
  output logic [NREQ-1:0][CCW-1:0]         r_bdo,
  output logic [NREQ-1:0]                  r_bdo_valid,
  output logic [NREQ-1:0][3:0]             r_bdo_type,
  output logic [NREQ-1:0]                  r_bdo_eot,
  input  logic [NREQ-1:0]                  r_bdo_ready,
  input  logic [NREQ-1:0]                  r_bdo_eoo,
  output logic [NREQ-1:0]                  r_auth,
  output logic [NREQ-1:0]                  r_auth_valid,
  output logic [3:0]                       c_mode,
  output logic [CCW-1:0]                   c_key,
  output logic                             c_key_valid,
  input  logic                             c_key_ready,
  output logic [CCW-1:0]                   c_bdi,
  output logic [CCWD8-1:0]                 c_bdi_valid,
  output logic [3:0]                       c_bdi_type,
  output logic                             c_bdi_eot,
  output logic                             c_bdi_eoi,
  input  logic                             c_bdi_ready,
  input  logic [CCW-1:0]                   c_bdo,
  input  logic                             c_bdo_valid,
  input  logic [3:0]                       c_bdo_type,
  input  logic                             c_bdo_eot,
  output logic                             c_bdo_ready,
  output logic                             c_bdo_eoo,
  input  logic                             c_auth,
  input  logic                             c_auth_valid,
  input  logic                             c_done,
  output logic                             busy,
  output logic [$clog2(NREQ)-1:0]          owner
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;

  logic [NREQ-1:0] elig, pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = r_req[i] && (r_mode[i] != M_NOP);
  end

  ascon_arb_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .elig_i (elig),
    .last_i (last_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StStart;
          gnt_d   = pick;
          owner_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      StStart: state_d = StBusy;
      StBusy:  if (c_done) state_d = StRel;
      StRel: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Owner's request-side inputs are only sampled in START; later changes are ignored.
  always_comb begin
    c_mode       = (state_q == StStart) ? r_mode[owner_q] : 4'd0;
    c_key        = '0;
    c_key_valid  = 1'b0;
    c_bdi        = '0;
    c_bdi_valid  = '0;
    c_bdi_type   = '0;
    c_bdi_eot    = 1'b0;
    c_bdi_eoi    = 1'b0;
    c_bdo_ready  = 1'b0;
    c_bdo_eoo    = 1'b0;
    r_key_ready  = '0;
    r_bdi_ready  = '0;
    r_bdo        = '0;
    r_bdo_valid  = '0;
    r_bdo_type   = '0;
    r_bdo_eot    = '0;
    r_auth       = '0;
    r_auth_valid = '0;
    r_done       = '0;
    if (state_q == StStart || state_q == StBusy) begin
      c_key                = r_key[owner_q];
      c_key_valid          = r_key_valid[owner_q];
      c_bdi                = r_bdi[owner_q];
      c_bdi_valid          = r_bdi_valid[owner_q];
      c_bdi_type           = r_bdi_type[owner_q];
      c_bdi_eot            = r_bdi_eot[owner_q];
      c_bdi_eoi            = r_bdi_eoi[owner_q];
      c_bdo_ready          = r_bdo_ready[owner_q];
      c_bdo_eoo            = r_bdo_eoo[owner_q];
      r_key_ready[owner_q] = c_key_ready;
      r_bdi_ready[owner_q] = c_bdi_ready;
      r_bdo[owner_q]       = c_bdo;
      r_bdo_valid[owner_q] = c_bdo_valid;
      r_bdo_type[owner_q]  = c_bdo_type;
      r_bdo_eot[owner_q]   = c_bdo_eot;
    end
    if (state_q == StBusy || state_q == StRel) begin
      r_auth[owner_q]       = c_auth;
      r_auth_valid[owner_q] = c_auth_valid;
    end
    if (state_q == StRel) r_done[owner_q] = 1'b1;
  end

  assign busy  = (state_q != StIdle);
  assign r_gnt = gnt_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter; the core side is driven directly by the bench.
module tb_ascon_arbiter;
  import ascon_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned CCW   = 32;
  localparam int unsigned CCWD8 = CCW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]            r_req, r_gnt, r_done;
  logic [NREQ-1:0][3:0]       r_mode;
  logic [NREQ-1:0][CCW-1:0]   r_key;
  logic [NREQ-1:0]            r_key_valid, r_key_ready;
  logic [NREQ-1:0][CCW-1:0]   r_bdi;
  logic [NREQ-1:0][CCWD8-1:0] r_bdi_valid;
  logic [NREQ-1:0][3:0]       r_bdi_type;
  logic [NREQ-1:0]            r_bdi_eot, r_bdi_eoi, r_bdi_ready;
  logic [NREQ-1:0][CCW-1:0]   r_bdo;
  logic [NREQ-1:0]            r_bdo_valid;
  logic [NREQ-1:0][3:0]       r_bdo_type;
  logic [NREQ-1:0]            r_bdo_eot, r_bdo_ready, r_bdo_eoo, r_auth, r_auth_valid;
  logic [3:0]                 c_mode;
  logic [CCW-1:0]             c_key;
  logic                       c_key_valid, c_key_ready;
  logic [CCW-1:0]             c_bdi;
  logic [CCWD8-1:0]           c_bdi_valid;
  logic [3:0]                 c_bdi_type;
  logic                       c_bdi_eot, c_bdi_eoi, c_bdi_ready;
  logic [CCW-1:0]             c_bdo;
  logic                       c_bdo_valid;
  logic [3:0]                 c_bdo_type;
  logic                       c_bdo_eot, c_bdo_ready, c_bdo_eoo;
  logic                       c_auth, c_auth_valid, c_done;
  logic                       busy;
  logic [$clog2(NREQ)-1:0]    owner;

  int n_total = 0;
  int n_bad   = 0;
  logic [1:0] exp_gnt [3];

  always #5 clk = ~clk;

  ascon_arbiter #(
    .NREQ(NREQ),
    .CCW (CCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .r_req       (r_req),
    .r_gnt       (r_gnt),
    .r_done      (r_done),
    .r_mode      (r_mode),
    .r_key       (r_key),
    .r_key_valid (r_key_valid),
    .r_key_ready (r_key_ready),
    .r_bdi       (r_bdi),
    .r_bdi_valid (r_bdi_valid),
    .r_bdi_type  (r_bdi_type),
    .r_bdi_eot   (r_bdi_eot),
    .r_bdi_eoi   (r_bdi_eoi),
    .r_bdi_ready (r_bdi_ready),
    .r_bdo       (r_bdo),
    .r_bdo_valid (r_bdo_valid),
    .r_bdo_type  (r_bdo_type),
    .r_bdo_eot   (r_bdo_eot),
    .r_bdo_ready (r_bdo_ready),
    .r_bdo_eoo   (r_bdo_eoo),
    .r_auth      (r_auth),
    .r_auth_valid(r_auth_valid),
    .c_mode      (c_mode),
    .c_key       (c_key),
    .c_key_valid (c_key_valid),
    .c_key_ready (c_key_ready),
    .c_bdi       (c_bdi),
    .c_bdi_valid (c_bdi_valid),
    .c_bdi_type  (c_bdi_type),
    .c_bdi_eot   (c_bdi_eot),
    .c_bdi_eoi   (c_bdi_eoi),
    .c_bdi_ready (c_bdi_ready),
    .c_bdo       (c_bdo),
    .c_bdo_valid (c_bdo_valid),
    .c_bdo_type  (c_bdo_type),
    .c_bdo_eot   (c_bdo_eot),
    .c_bdo_ready (c_bdo_ready),
    .c_bdo_eoo   (c_bdo_eoo),
    .c_auth      (c_auth),
    .c_auth_valid(c_auth_valid),
    .c_done      (c_done),
    .busy        (busy),
    .owner       (owner)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r_req = '0; r_mode = '0; r_key = '0; r_key_valid = '0;
    r_bdi = '0; r_bdi_valid = '0; r_bdi_type = '0; r_bdi_eot = '0; r_bdi_eoi = '0;
    r_bdo_ready = '0; r_bdo_eoo = '0;
    c_key_ready = 1'b0; c_bdi_ready = 1'b0; c_bdo = '0; c_bdo_valid = 1'b0;
    c_bdo_type = '0; c_bdo_eot = 1'b0; c_auth = 1'b0; c_auth_valid = 1'b0; c_done = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    check_eq("rst_gnt", 64'(r_gnt), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_owner", 64'(owner), 64'd0);
    check_eq("rst_cmode", 64'(c_mode), 64'd0);
    check_eq("rst_done", 64'(r_done), 64'd0);
    rst = 1'b0;

    // Request with mode 0 is not eligible.
    r_req = 2'b01;
    tick();
    tick();
    #1;
    check_eq("nop_gnt", 64'(r_gnt), 64'd0);
    check_eq("nop_busy", 64'(busy), 64'd0);

    // Hash on requester 0, eight 32-bit output words.
    r_mode[0] = M_HASH;
    tick();
    #1;
    check_eq("hash_gnt", 64'(r_gnt), 64'h1);
    check_eq("hash_cmode_start", 64'(c_mode), 64'(M_HASH));
    check_eq("hash_busy", 64'(busy), 64'd1);
    check_eq("hash_owner", 64'(owner), 64'd0);
    r_req = '0;
    tick();
    #1;
    check_eq("hash_cmode_busy", 64'(c_mode), 64'd0);
    r_bdo_ready = 2'b01;
    c_bdo_valid = 1'b1;
    c_bdo_type  = D_HASH;
    for (int w = 0; w < 8; w++) begin
      c_bdo     = 32'hA5C30000 + 32'(w * 17);
      c_bdo_eot = (w == 7);
      #1;
      check_eq($sformatf("hash_word%0d", w), 64'(r_bdo[0]), 64'(32'hA5C30000 + 32'(w * 17)));
      if (w == 0) begin
        check_eq("hash_bdo_valid", 64'(r_bdo_valid), 64'h1);
        check_eq("hash_bdo_ready", 64'(c_bdo_ready), 64'd1);
        check_eq("hash_bdo1_zero", 64'(r_bdo[1]), 64'd0);
      end
      if (w == 7) check_eq("hash_eot", 64'(r_bdo_eot), 64'h1);
      tick();
    end
    c_bdo_valid = 1'b0;
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    #1;
    check_eq("hash_done", 64'(r_done), 64'h1);
    check_eq("hash_bdo_rel", 64'(r_bdo_valid), 64'd0);
    tick();
    #1;
    check_eq("hash_done_clr", 64'(r_done), 64'd0);
    check_eq("hash_gnt_clr", 64'(r_gnt), 64'd0);
    check_eq("hash_idle", 64'(busy), 64'd0);
    clear_inputs();

    // Decrypt on requester 1 with failing tag.
    r_mode[1] = M_DEC;
    r_req = 2'b10;
    tick();
    #1;
    check_eq("dec_gnt", 64'(r_gnt), 64'h2);
    check_eq("dec_owner", 64'(owner), 64'd1);
    check_eq("dec_cmode", 64'(c_mode), 64'(M_DEC));
    r_req = '0;
    tick();
    c_auth = 1'b0;
    c_auth_valid = 1'b1;
    c_done = 1'b1;
    #1;
    check_eq("dec_auth_valid", 64'(r_auth_valid), 64'h2);
    check_eq("dec_auth", 64'(r_auth), 64'h0);
    tick();
    c_done = 1'b0;
    #1;
    check_eq("dec_auth_valid_rel", 64'(r_auth_valid), 64'h2);
    check_eq("dec_done", 64'(r_done), 64'h2);
    tick();
    #1;
    check_eq("dec_auth_idle", 64'(r_auth_valid), 64'h0);
    clear_inputs();

    // Owner drops request and changes mode mid-op; bdi routed only to owner.
    r_mode[0] = M_ENC;
    r_req = 2'b01;
    c_bdi_ready = 1'b1;
    r_bdi[0] = 32'hDEADBEEF;
    r_bdi[1] = 32'h12345678;
    r_bdi_valid[0] = 4'hF;
    r_bdi_valid[1] = 4'h3;
    tick();
    #1;
    check_eq("drop_bdi_ready_start", 64'(r_bdi_ready), 64'h1);
    check_eq("drop_cbdi", 64'(c_bdi), 64'hDEADBEEF);
    check_eq("drop_cbdi_valid", 64'(c_bdi_valid), 64'hF);
    tick();
    r_req = '0;
    r_mode[0] = M_NOP;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("drop_bdi_ready%0d", c), 64'(r_bdi_ready), 64'h1);
      check_eq($sformatf("drop_busy%0d", c), 64'(busy), 64'd1);
      tick();
    end
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    #1;
    check_eq("drop_done", 64'(r_done), 64'h1);
    check_eq("drop_bdi_ready_rel", 64'(r_bdi_ready), 64'h0);
    tick();
    #1;
    check_eq("drop_idle", 64'(busy), 64'd0);
    clear_inputs();

    // Reset in BUSY, then the same request is served again.
    r_mode[1] = M_ENC;
    r_req = 2'b10;
    tick();
    tick();
    #1;
    check_eq("rstb_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstb_gnt", 64'(r_gnt), 64'd0);
    check_eq("rstb_idle", 64'(busy), 64'd0);
    check_eq("rstb_cmode", 64'(c_mode), 64'd0);
    check_eq("rstb_owner", 64'(owner), 64'd0);
    tick();
    #1;
    check_eq("rstb_regnt", 64'(r_gnt), 64'h2);
    check_eq("rstb_recmode", 64'(c_mode), 64'(M_ENC));
    r_req = '0;
    tick();
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    #1;
    check_eq("rstb_done", 64'(r_done), 64'h2);
    tick();
    clear_inputs();

    // Both requesting continuously: grant order and 4-cycle grant-to-grant spacing.
`ifdef ASCON_ARB_RR_EN
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
`else
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
`endif
    r_mode[0] = M_ENC;
    r_mode[1] = M_ENC;
    r_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check_eq($sformatf("both_gnt%0d", k), 64'(r_gnt), 64'(exp_gnt[k]));
      check_eq($sformatf("both_cmode%0d", k), 64'(c_mode), 64'(M_ENC));
      tick();
      c_done = 1'b1;
      tick();
      c_done = 1'b0;
      #1;
      check_eq($sformatf("both_done%0d", k), 64'(r_done), 64'(exp_gnt[k]));
      tick();
      #1;
      check_eq($sformatf("both_gap_gnt%0d", k), 64'(r_gnt), 64'd0);
      check_eq($sformatf("both_gap_busy%0d", k), 64'(busy), 64'd0);
    end
    r_req = '0;
    tick();
    tick();
    #1;
    check_eq("end_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
